// File: rtl/fp_pkg.sv
// fp_pkg: IEEE-754 single constants, exception-flag bit indices and
// operand classes shared by fp_classify and fp_div_issue_ctrl.
package fp_pkg;

  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam int          FP_EXP_BIAS = 127;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

  localparam int FLAG_NV = 3;
  localparam int FLAG_DZ = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 0;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational single-precision operand classifier.
// Ports: in_val[31:0] operand, cls class; denormals report as ZERO.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] in_val,
  output fp_class_e   cls
);

  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  logic        unused_sign;

  assign exp_f       = in_val[30:23];
  assign frac_f      = in_val[22:0];
  assign unused_sign = in_val[31];

  // exp==0 covers both true zero and flushed denormals
  always_comb begin
    cls = NORM;
    unique case (1'b1)
      exp_f == 8'd0:
        cls = ZERO;
      exp_f == FP_EXP_MAX && frac_f == 23'd0:
        cls = INF;
      exp_f == FP_EXP_MAX && frac_f != 23'd0:
        cls = NAN;
      default:
        cls = NORM;
    endcase
  end

endmodule

// File: rtl/fp_div_issue_ctrl.sv
// fp_div_issue_ctrl: valid/ready wrapper around the external combinational
// FloatingDivision datapath. Holds div_a/div_b for SETTLE_CYCLES, then
// captures div_result and patches sign/exponent and special operands.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_a/in_b operand side;
// div_a/div_b/div_result datapath side; out_valid/out_ready/out_result
// result side; out_flags {NV,DZ,OF,UF} only when FDIV_FLAGS_EN is defined.
module fp_div_issue_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
`ifdef FDIV_FLAGS_EN
  ,
  output logic [3:0]  out_flags
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] div_a_d, div_b_d, res_d;
  logic        sign_q, sign_d, sign_in;
  fp_class_e   cls_a, cls_b;
  logic        spec_hit;
  logic [31:0] spec_res, norm_res;
  logic        lt;
  logic signed [9:0] e_n;
  logic        unused_hi;
`ifdef FDIV_FLAGS_EN
  logic [3:0]  spec_flg, norm_flg;
  logic [3:0]  flg_q, flg_d;
`endif

  fp_classify u_cls_a (.in_val(in_a), .cls(cls_a));
  fp_classify u_cls_b (.in_val(in_b), .cls(cls_b));

  assign sign_in   = in_a[31] ^ in_b[31];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign unused_hi = ^div_result[31:23];

  // first match wins, so an if/else chain rather than a parallel case
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
`ifdef FDIV_FLAGS_EN
    spec_flg = '0;
`endif
    if (cls_a == NAN || cls_b == NAN ||
        (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF && cls_b == INF)) begin
      spec_res = FP_QNAN;
`ifdef FDIV_FLAGS_EN
      spec_flg[FLAG_NV] = 1'b1;
`endif
    end else if (cls_a == NORM && cls_b == ZERO) begin
      spec_res = {sign_in, FP_EXP_MAX, 23'd0};
`ifdef FDIV_FLAGS_EN
      spec_flg[FLAG_DZ] = 1'b1;
`endif
    end else if (cls_a == INF) begin
      spec_res = {sign_in, FP_EXP_MAX, 23'd0};
    end else if (cls_a == ZERO || cls_b == INF) begin
      spec_res = {sign_in, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // quotient mantissa below 1.0 costs one exponent step
  assign lt  = div_a[22:0] < div_b[22:0];
  assign e_n = $signed({2'b00, div_a[30:23]})
             - $signed({2'b00, div_b[30:23]})
             + $signed(10'(FP_EXP_BIAS))
             - $signed({9'd0, lt});

  always_comb begin
    norm_res = {sign_q, e_n[7:0], div_result[22:0]};
`ifdef FDIV_FLAGS_EN
    norm_flg = '0;
`endif
    if (e_n >= 10'sd255) begin
      norm_res = {sign_q, FP_EXP_MAX, 23'd0};
`ifdef FDIV_FLAGS_EN
      norm_flg[FLAG_OF] = 1'b1;
`endif
    end else if (e_n <= 10'sd0) begin
      norm_res = {sign_q, 31'd0};
`ifdef FDIV_FLAGS_EN
      norm_flg[FLAG_UF] = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a;
    div_b_d = div_b;
    sign_d  = sign_q;
    res_d   = out_result;
`ifdef FDIV_FLAGS_EN
    flg_d   = flg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_a_d = in_a;
          div_b_d = in_b;
          sign_d  = sign_in;
          if (spec_hit) begin
            res_d   = spec_res;
`ifdef FDIV_FLAGS_EN
            flg_d   = spec_flg;
`endif
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          res_d   = norm_res;
`ifdef FDIV_FLAGS_EN
          flg_d   = norm_flg;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef FDIV_FLAGS_EN
          flg_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_a      <= '0;
      div_b      <= '0;
      sign_q     <= 1'b0;
      out_result <= '0;
`ifdef FDIV_FLAGS_EN
      flg_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_a      <= div_a_d;
      div_b      <= div_b_d;
      sign_q     <= sign_d;
      out_result <= res_d;
`ifdef FDIV_FLAGS_EN
      flg_q      <= flg_d;
`endif
    end
  end

`ifdef FDIV_FLAGS_EN
  assign out_flags = flg_q;
`endif

endmodule

// File: tb/tb_fp_div_issue_ctrl.sv
// Bench for fp_div_issue_ctrl: directed corner vectors plus random
// operand pairs scored against a plain-arithmetic division reference.
module tb_fp_div_issue_ctrl;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] div_a, div_b, div_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
`ifdef FDIV_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  int total = 0;
  int passed = 0;

  // stand-in for FloatingDivision: garbage until operands have settled
  int          age = 1000;
  logic [31:0] qv = '0;
  logic [31:0] junk = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) age <= 1;
    else if (age < 1000) age <= age + 1;
    junk <= $urandom;
  end

  assign div_result = (age >= SETTLE) ? qv : junk;

  fp_div_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result)
`ifdef FDIV_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  // 0 zero/denormal, 1 normal, 2 inf, 3 nan
  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'd0) return 0;
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 2 : 3;
    return 1;
  endfunction

  function automatic void ref_div(
    input  logic [31:0] a, b, q,
    output logic [31:0] r,
    output logic [3:0]  f,
    output bit          sp);
    int ca, cb, e;
    logic s;
    ca = cls(a);
    cb = cls(b);
    s  = a[31] ^ b[31];
    f  = 4'b0000;
    sp = 1'b1;
    if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) ||
        (ca == 2 && cb == 2)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (ca == 1 && cb == 0) begin
      r = {s, 8'hFF, 23'd0}; f = 4'b0100;
    end else if (ca == 2) begin
      r = {s, 8'hFF, 23'd0};
    end else if (ca == 0 || cb == 2) begin
      r = {s, 31'd0};
    end else begin
      sp = 1'b0;
      e = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (a[22:0] < b[22:0]) e = e - 1;
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'd0}; f = 4'b0001;
      end else begin
        r = {s, 8'(e), q[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 9);
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case (k)
      0: begin e = 8'd0; f = 23'd0; end
      1: begin e = 8'd0; if (f == 23'd0) f = 23'd1; end
      2: begin e = 8'hFF; f = 23'd0; end
      3: begin e = 8'hFF; if (f == 23'd0) f = 23'd1; end
      4: e = 8'($urandom_range(235, 254));
      5: e = 8'($urandom_range(1, 20));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {s, e, f};
  endfunction

  task automatic launch(input logic [31:0] a, b, q,
                        output int edges);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; qv = q;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    edges = 1;
    while (out_valid !== 1'b1 && edges < 300) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, b, q,
                       input int hold);
    logic [31:0] er;
    logic [3:0]  ef;
    logic [3:0]  ef_unused;
    bit sp;
    int edges, lat;
    ref_div(a, b, q, er, ef, sp);
    lat = sp ? 1 : SETTLE + 1;
    launch(a, b, q, edges);
    total++;
    if (edges !== lat)
      $display("FAIL latency %h/%h: got %0d want %0d",
               a, b, edges, lat);
    else passed++;
    total++;
    if (out_result !== er)
      $display("FAIL result %h/%h: got %h want %h",
               a, b, out_result, er);
    else passed++;
`ifdef FDIV_FLAGS_EN
    total++;
    if (out_flags !== ef)
      $display("FAIL flags %h/%h: got %b want %b",
               a, b, out_flags, ef);
    else passed++;
`else
    ef_unused = ef;
`endif
    total++;
    if ({div_a, div_b} !== {a, b})
      $display("FAIL div_ab: got %h %h want %h %h",
               div_a, div_b, a, b);
    else passed++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (out_result !== er || out_valid !== 1'b1 ||
          in_ready !== 1'b0
`ifdef FDIV_FLAGS_EN
          || out_flags !== ef
`endif
          )
        $display("FAIL hold: res %h v %b rdy %b want %h v 1 rdy 0",
                 out_result, out_valid, in_ready, er);
      else passed++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL release: rdy %b v %b want rdy 1 v 0",
               in_ready, out_valid);
    else passed++;
`ifdef FDIV_FLAGS_EN
    total++;
    if (out_flags !== 4'b0000)
      $display("FAIL flag_clear: got %b want 0000", out_flags);
    else passed++;
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        div_a !== 32'd0 || div_b !== 32'd0 ||
        out_result !== 32'd0)
      $display("FAIL reset_hold: rdy %b v %b a %h b %h r %h want 1 0 0 0 0",
               in_ready, out_valid, div_a, div_b, out_result);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_result !== 32'd0)
      $display("FAIL reset_rel: rdy %b v %b r %h want 1 0 0",
               in_ready, out_valid, out_result);
    else passed++;
`ifdef FDIV_FLAGS_EN
    total++;
    if (out_flags !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", out_flags);
    else passed++;
`endif
  endtask

  task automatic test_directed();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vq [6];
    va = '{32'h40C00000, 32'h3F800000, 32'h00000000,
           32'hBF800000, 32'h7F000000, 32'h00800000};
    vb = '{32'h40000000, 32'h00000000, 32'h80000000,
           32'h7F800000, 32'h00800000, 32'h7F000000};
    vq = '{32'h40400000, 32'h12345678, 32'h0,
           32'h0, 32'h3F800000, 32'h3F800000};
    for (int i = 0; i < 6; i++) do_op(va[i], vb[i], vq[i], 1);
  endtask

  task automatic test_backpressure();
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 10);
  endtask

  task automatic test_back_to_back();
    int edges;
    launch(32'h40C00000, 32'h40000000, 32'h40400000, edges);
    total++;
    if (out_result !== 32'h40400000)
      $display("FAIL b2b_first: got %h want 40400000", out_result);
    else passed++;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    in_a = 32'h3F800000; in_b = 32'h00000000;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        div_a !== 32'h40C00000)
      $display("FAIL b2b_noaccept: rdy %b v %b a %h want 1 0 40c00000",
               in_ready, out_valid, div_a);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (div_a !== 32'h3F800000 || out_valid !== 1'b1 ||
        out_result !== 32'h7F800000)
      $display("FAIL b2b_accept: a %h v %b r %h want 3f800000 1 7f800000",
               div_a, out_valid, out_result);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        div_a !== 32'd0 || out_result !== 32'd0)
      $display("FAIL mid_reset: v %b rdy %b a %h r %h want 0 1 0 0",
               out_valid, in_ready, div_a, out_result);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SETTLE + 2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_release: v %b rdy %b want 0 1",
               out_valid, in_ready);
    else passed++;
    do_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b, q;
    for (int n = 0; n < 200; n++) begin
      a = rnd_op();
      b = rnd_op();
      q = $urandom;
      do_op(a, b, q, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
